uart_tx_scheduler: RTL and testbench

Sequences the UART transmit path around the shared TX byte FIFO. Two byte producers feed a write-side arbiter: port 0 is the RX echo path and port 1 is the status/message generator. A drain FSM pops the FIFO one byte at a time and hands each byte to the UART transmitter through a start/busy handshake. The block sits between the producers, the FIFO's write/read ports and the transmitter.

---
 rtl/uart_tx_scheduler.sv | 121 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-producer write arbiter into the TX byte FIFO plus a drain FSM
// that hands bytes to the UART transmitter. Define UART_TX_FIXED_PRIO_EN for fixed port-0 priority.
module uart_tx_scheduler #(
  parameter int WIDTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wdata,
  input  logic             fifo_full,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  input  logic             drain_en,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_busy,
  output logic             timeout_err,
  output logic             last_grant
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, SETTLE} state_t;

  // timeout_err is registered, so it fires one count early and lands
  // exactly BUSY_TIMEOUT cycles after tx_start.
  localparam logic [7:0] TMO_FIRE = 8'(BUSY_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             tx_start_q, tx_start_d;
  logic             rd_en_q, rd_en_d;
  logic             timeout_q, timeout_d;
  logic             last_grant_q, last_grant_d;
  logic             any_valid, winner, wr_ok;

  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef UART_TX_FIXED_PRIO_EN
    winner = ~req0_valid;
`else
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else                          winner = ~req0_valid;
`endif
    wr_ok        = any_valid & ~fifo_full;
    last_grant_d = wr_ok ? winner : last_grant_q;
  end

  assign req0_ready = wr_ok & ~winner;
  assign req1_ready = wr_ok & winner;
  assign fifo_wr_en = wr_ok;
  assign fifo_wdata = wr_ok ? (winner ? req1_data : req0_data) : '0;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE:      if (drain_en && !fifo_empty) state_d = LOAD;
      LOAD: begin
        tx_data_d = fifo_rdata;
        state_d   = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d >= TMO_FIRE) begin
            timeout_d = 1'b1;
            state_d   = SETTLE;
          end
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = SETTLE;
      SETTLE:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    tx_start_d = (state_d == START);
    rd_en_d    = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      cnt_q        <= '0;
      tx_start_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      timeout_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      cnt_q        <= cnt_d;
      tx_start_q   <= tx_start_d;
      rd_en_q      <= rd_en_d;
      timeout_q    <= timeout_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign fifo_rd_en  = rd_en_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_q;
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: a queue-based FIFO, a transmitter model and a
// byte scoreboard predict arbitration, drain order and timeout timing.
module tb_uart_tx_scheduler;
  localparam int W = 8;
  localparam int T = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, fifo_wr_en, fifo_rd_en, tx_start, timeout_err, last_grant;
  logic [W-1:0] fifo_wdata, tx_data;
  logic fifo_full = 1'b0, fifo_empty = 1'b1, drain_en = 1'b0, tx_busy = 1'b0;
  logic [W-1:0] fifo_rdata = '0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.WIDTH(W), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .drain_en(drain_en), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .timeout_err(timeout_err), .last_grant(last_grant)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] sb_q[$];
  int m_lg = 1;
  int n0 = 0, n1 = 0;
  int tx_cnt = 0;
  int cyc = 0;
  int last_start = -100, last_rd = -100;
  bit tmo_pending = 0;
  int tmo_at = 0;
  int tmo_seen = 0;

  // Knobs
  int v_mode = 0;
  bit rst_req = 1, force_full = 0, drain_rand = 0, tx_dead = 0, l_rand = 0;
  bit inject = 0;
  logic [W-1:0] inject_byte = '0;
  int busy_len = 10;

  task automatic step();
    int win;
    bit wr;
    logic [W-1:0] wbyte;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    case (v_mode)
      1: begin
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = W'(8'hA0 + n0); req1_data = W'(8'hB0 + n1);
      end
      2: begin
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        req0_data = W'($urandom); req1_data = W'($urandom);
      end
      default: begin req0_valid = 1'b0; req1_valid = 1'b0; end
    endcase
    if (inject) begin
      req0_valid = 1'b1; req1_valid = 1'b0; req0_data = inject_byte;
    end
    if (rst_req) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    fifo_full  = force_full || (fifo_q.size() >= DEPTH - 1);
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? W'($urandom) : fifo_q[0];
    if (drain_rand) drain_en = 1'($urandom_range(0, 1));
    tx_busy = (tx_cnt > 0);
    #1;
    if (rst_req) begin
      m_lg = 1; tx_cnt = 0; tmo_pending = 0; last_start = -100; last_rd = -100;
      return;
    end
    // Arbitration rule: with both valid, the index other than last_grant wins.
    if (req0_valid && req1_valid) begin
`ifdef UART_TX_FIXED_PRIO_EN
      win = 0;
`else
      win = 1 - m_lg;
`endif
    end else begin
      win = req0_valid ? 0 : 1;
    end
    wr = (req0_valid || req1_valid) && !fifo_full;
    wbyte = (win == 0) ? req0_data : req1_data;
    chk("req0_ready", 32'(req0_ready), 32'(wr && win == 0));
    chk("req1_ready", 32'(req1_ready), 32'(wr && win == 1));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(wr));
    chk("fifo_wdata", 32'(fifo_wdata), wr ? 32'(wbyte) : 32'd0);
    chk("last_grant", 32'(last_grant), 32'(m_lg));
    chk("timeout_err", 32'(timeout_err), 32'(tmo_pending && cyc == tmo_at));
    if (timeout_err === 1'b1) tmo_seen++;
    if (tmo_pending && cyc >= tmo_at) tmo_pending = 0;
    if (fifo_rd_en === 1'b1) chk("pop_nonempty", 32'(fifo_empty), 32'd0);
    if (tx_start === 1'b1) begin
      chk("start_after_pop", 32'(cyc - last_rd), 32'd1);
      chk("start_interval_ge6", 32'((cyc - last_start) >= 6), 32'd1);
      if (sb_q.size() == 0) chk("spurious_tx_start", 32'(tx_start), 32'd0);
      else chk("tx_data", 32'(tx_data), 32'(sb_q.pop_front()));
      last_start = cyc;
      if (tx_dead) begin
        tmo_pending = 1; tmo_at = cyc + T;
      end
    end
    // Advance environment to the coming clock edge.
    if (wr) begin
      fifo_q.push_back(wbyte);
      sb_q.push_back(wbyte);
      m_lg = win;
      if (win == 0) n0++; else n1++;
    end
    if (fifo_rd_en === 1'b1) begin
      last_rd = cyc;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (tx_busy) tx_cnt--;
    if (tx_start === 1'b1 && !tx_dead) tx_cnt = l_rand ? $urandom_range(1, 4) : busy_len;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_last_grant"}, 32'(last_grant), 32'd1);
  endtask

  initial begin
    bit reached;
    // Reset
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();
    chk_reset_outputs("reset");

    // Both producers valid continuously; fills the FIFO to its full threshold.
    v_mode = 1;
    repeat (10) step();

    // Forced full with both valid: no writes, grant history frozen.
    force_full = 1;
    repeat (5) step();
    force_full = 0;
    v_mode = 0;

    // Drain everything with a 10-cycle busy transmitter.
    drain_en = 1; busy_len = 10;
    repeat (150) step();
    chk("drain_all", 32'(sb_q.size()), 32'd0);

    // Dead transmitter: single byte times out and is not resent.
    tx_dead = 1; inject = 1; inject_byte = 8'h33;
    step();
    inject = 0;
    repeat (40) step();
    chk("timeout_count", 32'(tmo_seen), 32'd1);
    tx_dead = 0;

    // Random traffic
    v_mode = 2; drain_rand = 1; l_rand = 1;
    repeat (600) step();
    v_mode = 0; drain_rand = 0; drain_en = 1;
    repeat (250) step();
    chk("random_drain_all", 32'(sb_q.size()), 32'd0);
    l_rand = 0;

    // Reset during WAIT_DONE
    busy_len = 20; inject = 1; inject_byte = 8'h5A;
    step();
    inject = 0;
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      if (tx_busy) reached = 1;
    end
    chk("reach_wait_done", 32'(reached), 32'd1);
    repeat (2) step();
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    chk_reset_outputs("mid_rst");
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_start_after_rst", 32'(tx_start), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
